// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the set-2 scan-code decoder.
package ps2_kbd_pkg;

    // Prefix bytes
    localparam logic [7:0] PS2_E0       = 8'hE0;
    localparam logic [7:0] PS2_F0       = 8'hF0;
    localparam logic [7:0] PS2_E1       = 8'hE1;

    // Device control replies
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PS2_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_OVR0     = 8'h00;
    localparam logic [7:0] PS2_OVR1     = 8'hFF;

    // Pause key is reported with this code once its E1 sequence completes
    localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

    // Decoder states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_E1SKIP
    } state_e;

    // Event record: {pause, break, ext, code[7:0]}
    localparam int unsigned EVT_W = 11;

    typedef struct packed {
        logic       pause;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } evt_t;

    // Control pulse vector bit positions
    localparam int unsigned CTL_N        = 6;
    localparam int unsigned CTL_ACK      = 0;
    localparam int unsigned CTL_RESEND   = 1;
    localparam int unsigned CTL_BAT_OK   = 2;
    localparam int unsigned CTL_BAT_FAIL = 3;
    localparam int unsigned CTL_ECHO     = 4;
    localparam int unsigned CTL_OVERRUN  = 5;

    // One-hot classification of a received byte as a control reply (zero if not one)
    function automatic logic [CTL_N-1:0] ctl_decode(input logic [7:0] b);
        logic [CTL_N-1:0] r;
        r = '0;
        case (b)
            PS2_ACK:            r[CTL_ACK]      = 1'b1;
            PS2_RESEND:         r[CTL_RESEND]   = 1'b1;
            PS2_BAT_OK:         r[CTL_BAT_OK]   = 1'b1;
            PS2_BAT_FAIL:       r[CTL_BAT_FAIL] = 1'b1;
            PS2_ECHO:           r[CTL_ECHO]     = 1'b1;
            PS2_OVR0, PS2_OVR1: r[CTL_OVERRUN]  = 1'b1;
            default:            r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_kbd_decoder_if.sv
// Byte input, event FIFO handshake and status signals of the keyboard decoder.
interface ps2_kbd_decoder_if;

    logic [7:0] bs_data_in;
    logic       bs_data_in_produce;

    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_pause;
    logic       evt_ready;

    logic       ctl_ack;
    logic       ctl_resend;
    logic       ctl_bat_ok;
    logic       ctl_bat_fail;
    logic       ctl_echo;
    logic       ctl_overrun;

    logic       overflow;
    logic       overflow_clr;

    // Decoder side
    modport master (
        input  bs_data_in, bs_data_in_produce, evt_ready, overflow_clr,
        output evt_valid, evt_code, evt_ext, evt_break, evt_pause,
        output ctl_ack, ctl_resend, ctl_bat_ok, ctl_bat_fail, ctl_echo, ctl_overrun,
        output overflow
    );

    // Byte source / event consumer side
    modport slave (
        output bs_data_in, bs_data_in_produce, evt_ready, overflow_clr,
        input  evt_valid, evt_code, evt_ext, evt_break, evt_pause,
        input  ctl_ack, ctl_resend, ctl_bat_ok, ctl_bat_fail, ctl_echo, ctl_overrun,
        input  overflow
    );

endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through FIFO; head is visible whenever not empty and reads as
// zero when empty. A push into a full FIFO is accepted if a pop happens the same cycle.
module ps2_evt_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care until written, output is masked when empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// Set-2 scan-code decoder: strips E0/F0/E1 prefixes, queues key events in a
// FWFT FIFO and reports device control replies as one-cycle pulses.
module ps2_kbd_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    ps2_kbd_decoder_if.master  bus
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q,  state_d;
    logic [TMO_W-1:0] tmo_q,    tmo_d;
    logic [2:0]       e1_cnt_q, e1_cnt_d;
    logic [CTL_N-1:0] ctl_q,    ctl_d;
    logic             ovf_q,    ovf_d;

    logic [CTL_N-1:0] ctl_hit;
    logic             push;
    evt_t             push_evt;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    evt_t             head;

    assign ctl_hit = ctl_decode(bus.bs_data_in);
    assign pop     = bus.evt_ready && !fifo_empty;

    // Decoder next-state, prefix timeout, E1 skip counter, event push and control pulses
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        e1_cnt_d = e1_cnt_q;
        ctl_d    = '0;
        push     = 1'b0;
        push_evt = '0;
        if (bus.bs_data_in_produce) begin
            tmo_d = '0;
            if (state_q == ST_E1SKIP) begin
                // Pause sequence bytes are consumed blindly, control codes included
                if (e1_cnt_q == 3'd1) begin
                    push          = 1'b1;
                    push_evt.pause = 1'b1;
                    push_evt.code  = PS2_PAUSE_CODE;
                    e1_cnt_d      = '0;
                    state_d       = ST_IDLE;
                end else begin
                    e1_cnt_d = e1_cnt_q - 1'b1;
                end
            end else if (|ctl_hit) begin
                ctl_d   = ctl_hit;
                state_d = ST_IDLE;
            end else if (bus.bs_data_in == PS2_E0) begin
                state_d = ST_E0;
            end else if (bus.bs_data_in == PS2_F0) begin
                if (state_q == ST_E0 || state_q == ST_E0F0) state_d = ST_E0F0;
                else                                        state_d = ST_F0;
            end else if (bus.bs_data_in == PS2_E1) begin
                state_d  = ST_E1SKIP;
                e1_cnt_d = 3'd7;
            end else begin
                push          = 1'b1;
                push_evt.brk  = (state_q == ST_F0) || (state_q == ST_E0F0);
                push_evt.ext  = (state_q == ST_E0) || (state_q == ST_E0F0);
                push_evt.code = bus.bs_data_in;
                state_d       = ST_IDLE;
            end
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d  = ST_IDLE;
                tmo_d    = '0;
                e1_cnt_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
    always_comb begin
        ovf_d = ovf_q;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        else if (bus.overflow_clr)     ovf_d = 1'b0;
    end

    // Decoder state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            tmo_q    <= '0;
            e1_cnt_q <= '0;
            ctl_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            e1_cnt_q <= e1_cnt_d;
            ctl_q    <= ctl_d;
            ovf_q    <= ovf_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.evt_valid    = !fifo_empty;
    assign bus.evt_code     = head.code;
    assign bus.evt_ext      = head.ext;
    assign bus.evt_break    = head.brk;
    assign bus.evt_pause    = head.pause;

    assign bus.ctl_ack      = ctl_q[CTL_ACK];
    assign bus.ctl_resend   = ctl_q[CTL_RESEND];
    assign bus.ctl_bat_ok   = ctl_q[CTL_BAT_OK];
    assign bus.ctl_bat_fail = ctl_q[CTL_BAT_FAIL];
    assign bus.ctl_echo     = ctl_q[CTL_ECHO];
    assign bus.ctl_overrun  = ctl_q[CTL_OVERRUN];

    assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed self-checking bench for the set-2 keyboard decoder.
module tb_ps2_kbd_decoder;

    localparam int unsigned TMO = 40;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    ps2_kbd_decoder_if bus ();

    ps2_kbd_decoder #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Head as {valid, pause, break, ext, code}
    function automatic logic [11:0] head_now();
        return {bus.evt_valid, bus.evt_pause, bus.evt_break, bus.evt_ext, bus.evt_code};
    endfunction

    // Control pulses as {ack, resend, bat_ok, bat_fail, echo, overrun}
    function automatic logic [5:0] ctl_now();
        return {bus.ctl_ack, bus.ctl_resend, bus.ctl_bat_ok,
                bus.ctl_bat_fail, bus.ctl_echo, bus.ctl_overrun};
    endfunction

    // All stimulus tasks start and end 1ns after a rising edge.
    // Drives a strobe for one cycle and leaves it asserted for back-to-back use.
    task automatic send_b2b(input logic [7:0] b);
        bus.bs_data_in         = b;
        bus.bs_data_in_produce = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_b2b(b);
        bus.bs_data_in_produce = 1'b0;
    endtask

    task automatic pop_one();
        bus.evt_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.evt_ready = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset                  = 1'b0;
        bus.bs_data_in         = '0;
        bus.bs_data_in_produce = 1'b0;
        bus.evt_ready          = 1'b0;
        bus.overflow_clr       = 1'b0;
        idle(3);
        total++;
        if (head_now() !== 12'h000) begin
            bad++;
            $display("FAIL reset_head: got %h want %h", head_now(), 12'h000);
        end
        total++;
        if ({ctl_now(), bus.overflow} !== 7'b0) begin
            bad++;
            $display("FAIL reset_status: got %b want %b", {ctl_now(), bus.overflow}, 7'b0);
        end
        reset = 1'b1;
        idle(2);
        total++;
        if (head_now() !== 12'h000) begin
            bad++;
            $display("FAIL after_reset_head: got %h want %h", head_now(), 12'h000);
        end
    endtask

    task automatic test_make_break();
        send_byte(8'h1C);
        total++;
        if (head_now() !== 12'h81C) begin
            bad++;
            $display("FAIL make_1c: got %h want %h", head_now(), 12'h81C);
        end
        pop_one();
        total++;
        if (head_now() !== 12'h000) begin
            bad++;
            $display("FAIL make_pop_empty: got %h want %h", head_now(), 12'h000);
        end
        send_byte(8'hF0);
        total++;
        if (head_now() !== 12'h000) begin
            bad++;
            $display("FAIL f0_no_event: got %h want %h", head_now(), 12'h000);
        end
        send_byte(8'h1C);
        total++;
        if (head_now() !== 12'hA1C) begin
            bad++;
            $display("FAIL break_1c: got %h want %h", head_now(), 12'hA1C);
        end
        pop_one();
    endtask

    task automatic test_extended();
        send_b2b(8'hE0);
        send_byte(8'h75);
        total++;
        if (head_now() !== 12'h975) begin
            bad++;
            $display("FAIL ext_make_75: got %h want %h", head_now(), 12'h975);
        end
        pop_one();
        send_b2b(8'hE0);
        send_b2b(8'hF0);
        send_byte(8'h75);
        total++;
        if (head_now() !== 12'hB75) begin
            bad++;
            $display("FAIL ext_break_75: got %h want %h", head_now(), 12'hB75);
        end
        pop_one();
        // Stray F0 before E0 is discarded by the E0
        send_b2b(8'hF0);
        send_b2b(8'hE0);
        send_byte(8'h12);
        total++;
        if (head_now() !== 12'h912) begin
            bad++;
            $display("FAIL f0_e0_discard: got %h want %h", head_now(), 12'h912);
        end
        pop_one();
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        logic       noise;
        seq   = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        noise = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_b2b(seq[i]);
            if (bus.evt_valid || (|ctl_now())) noise = 1'b1;
        end
        send_byte(seq[7]);
        total++;
        if (noise !== 1'b0) begin
            bad++;
            $display("FAIL pause_no_early_output: got %b want %b", noise, 1'b0);
        end
        total++;
        if ({head_now(), ctl_now()} !== {12'hC77, 6'b0}) begin
            bad++;
            $display("FAIL pause_event: got %h want %h", {head_now(), ctl_now()}, {12'hC77, 6'b0});
        end
        pop_one();
        total++;
        if (head_now() !== 12'h000) begin
            bad++;
            $display("FAIL pause_single: got %h want %h", head_now(), 12'h000);
        end
    endtask

    task automatic test_control();
        logic [7:0] cb  [5];
        logic [5:0] exp [5];
        cb  = '{8'hFE, 8'hFC, 8'hEE, 8'h00, 8'hFF};
        exp = '{6'b010000, 6'b000100, 6'b000010, 6'b000001, 6'b000001};
        send_byte(8'hFA);
        total++;
        if ({ctl_now(), bus.evt_valid} !== {6'b100000, 1'b0}) begin
            bad++;
            $display("FAIL ctl_ack_pulse: got %b want %b", {ctl_now(), bus.evt_valid}, 7'b1000000);
        end
        idle(1);
        total++;
        if (ctl_now() !== 6'b0) begin
            bad++;
            $display("FAIL ctl_ack_width: got %b want %b", ctl_now(), 6'b0);
        end
        send_byte(8'hF0);
        send_byte(8'hAA);
        total++;
        if ({ctl_now(), bus.evt_valid} !== {6'b001000, 1'b0}) begin
            bad++;
            $display("FAIL ctl_bat_ok_after_f0: got %b want %b", {ctl_now(), bus.evt_valid}, 7'b0010000);
        end
        for (int i = 0; i < 5; i++) begin
            send_byte(cb[i]);
            total++;
            if (ctl_now() !== exp[i]) begin
                bad++;
                $display("FAIL ctl_byte_%h: got %b want %b", cb[i], ctl_now(), exp[i]);
            end
        end
        send_byte(8'h1C);
        total++;
        if (head_now() !== 12'h81C) begin
            bad++;
            $display("FAIL ctl_then_plain_make: got %h want %h", head_now(), 12'h81C);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        total++;
        if ({head_now(), bus.overflow} !== {12'h801, 1'b1}) begin
            bad++;
            $display("FAIL ovf_full: got %h want %h", {head_now(), bus.overflow}, {12'h801, 1'b1});
        end
        // Push while full with a simultaneous pop is accepted
        bus.bs_data_in         = 8'h0A;
        bus.bs_data_in_produce = 1'b1;
        bus.evt_ready          = 1'b1;
        @(posedge clk);
        #1;
        bus.bs_data_in_produce = 1'b0;
        bus.evt_ready          = 1'b0;
        total++;
        if (head_now() !== 12'h802) begin
            bad++;
            $display("FAIL ovf_push_pop_full: got %h want %h", head_now(), 12'h802);
        end
        idle(2);
        total++;
        if (head_now() !== 12'h802) begin
            bad++;
            $display("FAIL ovf_head_stable: got %h want %h", head_now(), 12'h802);
        end
        for (int i = 2; i <= 8; i++) begin
            total++;
            if (head_now() !== {4'h8, 8'(i)}) begin
                bad++;
                $display("FAIL ovf_drain_%0d: got %h want %h", i, head_now(), {4'h8, 8'(i)});
            end
            pop_one();
        end
        total++;
        if (head_now() !== 12'h80A) begin
            bad++;
            $display("FAIL ovf_drain_last: got %h want %h", head_now(), 12'h80A);
        end
        pop_one();
        total++;
        if ({head_now(), bus.overflow} !== {12'h000, 1'b1}) begin
            bad++;
            $display("FAIL ovf_sticky: got %h want %h", {head_now(), bus.overflow}, {12'h000, 1'b1});
        end
        bus.overflow_clr = 1'b1;
        idle(1);
        bus.overflow_clr = 1'b0;
        total++;
        if (bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: got %b want %b", bus.overflow, 1'b0);
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hE0);
        idle(TMO - 5);
        send_byte(8'h75);
        total++;
        if (head_now() !== 12'h975) begin
            bad++;
            $display("FAIL tmo_before_expiry: got %h want %h", head_now(), 12'h975);
        end
        pop_one();
        send_byte(8'hE0);
        idle(TMO + 5);
        total++;
        if (head_now() !== 12'h000) begin
            bad++;
            $display("FAIL tmo_no_event: got %h want %h", head_now(), 12'h000);
        end
        send_byte(8'h1C);
        total++;
        if (head_now() !== 12'h81C) begin
            bad++;
            $display("FAIL tmo_then_make: got %h want %h", head_now(), 12'h81C);
        end
        pop_one();
        // Reset mid-sequence drops the queued event and the pending prefix
        send_byte(8'h1C);
        send_byte(8'hE0);
        reset = 1'b0;
        #1;
        total++;
        if (head_now() !== 12'h000) begin
            bad++;
            $display("FAIL rst_mid_flush: got %h want %h", head_now(), 12'h000);
        end
        idle(2);
        reset = 1'b1;
        idle(1);
        send_byte(8'h1C);
        total++;
        if (head_now() !== 12'h81C) begin
            bad++;
            $display("FAIL rst_mid_then_make: got %h want %h", head_now(), 12'h81C);
        end
        pop_one();
        total++;
        if (head_now() !== 12'h000) begin
            bad++;
            $display("FAIL rst_mid_single: got %h want %h", head_now(), 12'h000);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_make_break();
        test_extended();
        test_pause();
        test_control();
        test_overflow();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
